// File: rtl/hpdcache_demux_buf.sv
// hpdcache_demux_buf: steers one valid/ready request stream to one of NOUTPUT consumers
// through a registered output stage. Define HPDCACHE_DEMUX_SKID_EN to add a skid entry.
module hpdcache_demux_buf #(
   parameter int unsigned NOUTPUT     = 2,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ONE_HOT_SEL = 0,
   localparam int unsigned IDX_WIDTH  = $clog2(NOUTPUT),
   localparam int unsigned SEL_WIDTH  = (ONE_HOT_SEL != 0) ? NOUTPUT : IDX_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [SEL_WIDTH-1:0]  sel_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [NOUTPUT-1:0]    valid_o,
   input  logic [NOUTPUT-1:0]    ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  err_o
);

   logic                  in_legal;
   logic [IDX_WIDTH-1:0]  in_idx;
   logic                  accept;
   logic                  drain;

   logic                  main_valid_q;
   logic [IDX_WIDTH-1:0]  main_idx_q;
   logic [DATA_WIDTH-1:0] main_data_q;
   logic                  err_q;

`ifdef HPDCACHE_DEMUX_SKID_EN
   logic                  skid_valid_q;
   logic [IDX_WIDTH-1:0]  skid_idx_q;
   logic [DATA_WIDTH-1:0] skid_data_q;
`endif

   // Select decode: produce a port index plus a legality flag for either encoding
   generate
      if (ONE_HOT_SEL != 0) begin : g_onehot
         always_comb begin
            in_idx = '0;
            for (int k = 0; k < NOUTPUT; k++) begin
               if (sel_i[k]) begin
                  in_idx = IDX_WIDTH'(k);
               end
            end
         end
         assign in_legal = $onehot(sel_i);
      end else begin : g_binary
         assign in_idx = sel_i;
         if ((1 << IDX_WIDTH) == NOUTPUT) begin : g_full
            assign in_legal = 1'b1;
         end else begin : g_partial
            assign in_legal = (32'(sel_i) < 32'(NOUTPUT));
         end
      end
   endgenerate

   always_comb begin
      valid_o = '0;
      for (int k = 0; k < NOUTPUT; k++) begin
         valid_o[k] = main_valid_q && (main_idx_q == IDX_WIDTH'(k));
      end
   end

   // Only the port currently presented can drain the main stage
   assign drain   = |(valid_o & ready_i);
   assign data_o  = main_data_q;
   assign err_o   = err_q;

`ifdef HPDCACHE_DEMUX_SKID_EN
   assign ready_o = !skid_valid_q;
`else
   assign ready_o = !main_valid_q || drain;
`endif

   assign accept  = valid_i && ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_valid_q <= 1'b0;
         main_idx_q   <= '0;
         main_data_q  <= '0;
         err_q        <= 1'b0;
`ifdef HPDCACHE_DEMUX_SKID_EN
         skid_valid_q <= 1'b0;
         skid_idx_q   <= '0;
         skid_data_q  <= '0;
`endif
      end else begin
         err_q <= accept && !in_legal;
`ifdef HPDCACHE_DEMUX_SKID_EN
         // A full skid blocks input; it refills main the moment main drains
         if (skid_valid_q) begin
            if (drain) begin
               main_idx_q   <= skid_idx_q;
               main_data_q  <= skid_data_q;
               skid_valid_q <= 1'b0;
            end
         end else if (accept && in_legal) begin
            if (!main_valid_q || drain) begin
               main_valid_q <= 1'b1;
               main_idx_q   <= in_idx;
               main_data_q  <= data_i;
            end else begin
               skid_valid_q <= 1'b1;
               skid_idx_q   <= in_idx;
               skid_data_q  <= data_i;
            end
         end else if (drain) begin
            main_valid_q <= 1'b0;
         end
`else
         if (accept && in_legal) begin
            main_valid_q <= 1'b1;
            main_idx_q   <= in_idx;
            main_data_q  <= data_i;
         end else if (drain) begin
            main_valid_q <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_hpdcache_demux_buf.sv
// tb_hpdcache_demux_buf: randomized and directed scoreboard bench for hpdcache_demux_buf
// with NOUTPUT=3 and binary select, so select value 3 is illegal.
module tb_hpdcache_demux_buf;

   localparam int NOUT = 3;
   localparam int DW   = 32;

   logic            clk;
   logic            rst_n;
   logic            valid_i;
   logic            ready_o;
   logic [1:0]      sel_i;
   logic [DW-1:0]   data_i;
   logic [NOUT-1:0] valid_o;
   logic [NOUT-1:0] ready_i;
   logic [DW-1:0]   data_o;
   logic            err_o;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   logic err_exp;
   int   tests_run;
   int   tests_failed;

   hpdcache_demux_buf #(
      .NOUTPUT(NOUT),
      .DATA_WIDTH(DW),
      .ONE_HOT_SEL(0)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .sel_i(sel_i),
      .data_i(data_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .data_o(data_o),
      .err_o(err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
      end
   endtask

   // One cycle of stimulus; called just after a rising edge, returns just after the next one
   task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [31:0] data,
                                input logic [NOUT-1:0] rdy);
      valid_i = v;
      sel_i   = sel;
      data_i  = data;
      ready_i = rdy;
      @(negedge clk);
      #1;
      err_exp = 1'b0;
      if (valid_i && ready_o) begin
         if (int'(sel_i) < NOUT) begin
            exp_q.push_back('{port: int'(sel_i), data: data_i});
         end else begin
            err_exp = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NOUT-1:0] portMask(input int p);
      logic [NOUT-1:0] m;
      m = '0;
      m[p] = 1'b1;
      return m;
   endfunction

   // Monitor: compare presented outputs with the scoreboard head, pop on handshake
   always @(negedge clk) begin
      if (rst_n) begin
         logic [NOUT-1:0] exp_valid;
         logic            exp_ready;
         exp_valid = (exp_q.size() > 0) ? portMask(exp_q[0].port) : '0;
`ifdef HPDCACHE_DEMUX_SKID_EN
         exp_ready = (exp_q.size() < 2);
`else
         exp_ready = (exp_q.size() == 0) || ready_i[exp_q[0].port];
`endif
         checkOutput("valid_o", 64'(valid_o), 64'(exp_valid));
         checkOutput("valid_onehot0", 64'($onehot0(valid_o)), 64'd1);
         checkOutput("ready_o", 64'(ready_o), 64'(exp_ready));
         checkOutput("err_o", 64'(err_o), 64'(err_exp));
         if (exp_q.size() > 0) begin
            checkOutput("data_o", 64'(data_o), 64'(exp_q[0].data));
            if ((valid_o & ready_i) != '0) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      err_exp      = 1'b0;
      rst_n        = 1'b0;
      valid_i      = 1'b0;
      sel_i        = '0;
      data_i       = '0;
      ready_i      = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid_o", 64'(valid_o), 64'd0);
      checkOutput("reset_data_o", 64'(data_o), 64'd0);
      checkOutput("reset_err_o", 64'(err_o), 64'd0);
      checkOutput("reset_ready_o", 64'(ready_o), 64'd1);
      rst_n = 1'b1;

      // Single transfer, latency one cycle
      applyStimulus(1'b1, 2'd2, 32'hA5, 3'b111);
      checkOutput("t1_valid_o", 64'(valid_o), 64'b100);
      checkOutput("t1_data_o", 64'(data_o), 64'hA5);
      applyStimulus(1'b0, 2'd0, 32'h0, 3'b111);
      checkOutput("t1_valid_clear", 64'(valid_o), 64'd0);

      // Back-to-back stream across ports
      applyStimulus(1'b1, 2'd0, 32'h100, 3'b111);
      checkOutput("t2_valid0", 64'(valid_o), 64'b001);
      applyStimulus(1'b1, 2'd1, 32'h101, 3'b111);
      checkOutput("t2_valid1", 64'(valid_o), 64'b010);
      checkOutput("t2_ready1", 64'(ready_o), 64'd1);
      applyStimulus(1'b1, 2'd2, 32'h102, 3'b111);
      checkOutput("t2_valid2", 64'(valid_o), 64'b100);
      applyStimulus(1'b1, 2'd0, 32'h103, 3'b111);
      checkOutput("t2_valid3", 64'(valid_o), 64'b001);
      checkOutput("t2_data3", 64'(data_o), 64'h103);
      applyStimulus(1'b0, 2'd0, 32'h0, 3'b111);

      // Stall on port 1 with a second request pending at the input
      applyStimulus(1'b1, 2'd1, 32'h11, 3'b101);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 2'd0, 32'h22 + i, 3'b101);
         checkOutput("t3_hold_valid", 64'(valid_o), 64'b010);
         checkOutput("t3_hold_data", 64'(data_o), 64'h11);
      end
      repeat (3) applyStimulus(1'b0, 2'd0, 32'h0, 3'b111);

      // Illegal select: error pulse for exactly one cycle, no output valid
      applyStimulus(1'b1, 2'd3, 32'hBAD, 3'b111);
      checkOutput("t4_err_pulse", 64'(err_o), 64'd1);
      checkOutput("t4_no_valid", 64'(valid_o), 64'd0);
      applyStimulus(1'b0, 2'd0, 32'h0, 3'b111);
      checkOutput("t4_err_clear", 64'(err_o), 64'd0);

      // Asynchronous reset while port 2 is stalled
      applyStimulus(1'b1, 2'd2, 32'h77, 3'b000);
      applyStimulus(1'b0, 2'd0, 32'h0, 3'b000);
      checkOutput("t5_pending", 64'(valid_o), 64'b100);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 64'(valid_o), 64'd0);
      checkOutput("t5_rst_err", 64'(err_o), 64'd0);
      exp_q.delete();
      err_exp = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("t5_ready_after", 64'(ready_o), 64'd1);

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         logic [NOUT-1:0] rdy;
         logic [1:0]      sel;
         for (int p = 0; p < NOUT; p++) begin
            rdy[p] = ($urandom_range(0, 9) < 7);
         end
         sel = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, NOUT - 1));
         applyStimulus(($urandom_range(0, 9) < 6), sel, $urandom, rdy);
      end
      repeat (4) applyStimulus(1'b0, 2'd0, 32'h0, 3'b111);
      checkOutput("final_drain_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
